glycemic_index_calculator: RTL and testbench
============================================

# glycemic_index_calculator

Converts the 8-bit blood-glucose sensor reading into a 4-bit glycemic index code, plus hypo- and hyper-glycemia alert flags. It sits between the blood-sensor interface and the health-monitor decision logic. It is a registered, single-clock block with a one-cycle valid handshake and an optional 4-sample smoothing filter.

## Interface
Parameters: none. Thresholds are fixed constants:
- HYPO_LIMIT = 8'd70
- HYPER_LIMIT = 8'd180

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge
- `rst_n`  input  1  reset; one clock, asynchronous, active-low
- `sample_valid`  input  1  `bloodSensor` holds a new reading this cycle
- `bloodSensor`  input  8  unsigned glucose reading, mg/dL, 0–255
- `glycemicIndex`  output  4  index code = (effective reading) >> 4, range 0–15
- `index_valid`  output  1  one-cycle pulse: outputs updated from a new sample
- `hypo_alert`  output  1  effective reading < HYPO_LIMIT
- `hyper_alert`  output  1  effective reading > HYPER_LIMIT

## Operation
- Effective reading R:
  - Without the filter, R = `bloodSensor` of the accepted sample.
  - With the filter, R = mean of the last 4 accepted samples, including the current one.
- `glycemicIndex` = R[7:4], i.e. floor(R/16). No rounding, no saturation needed because R ≤ 255.
- Alerts are strict comparisons:
  - R = 70 → `hypo_alert` = 0.
  - R = 180 → `hyper_alert` = 0.
  - Both alerts can never be 1 together.
- Filter datapath:
  - 4-entry shift history h0..h3 of 8-bit samples; new sample enters h0.
  - Sum is 10 bits (max 1020, no overflow); R = sum[9:2], truncating.
  - Priming: the first accepted sample after reset writes all four entries. The first output therefore equals that sample, not a quarter of it.
- Cycles with `sample_valid` = 0:
  - No state change.
  - `glycemicIndex` and the alerts hold their last values.
  - `index_valid` = 0.
- `bloodSensor` is ignored when `sample_valid` = 0.

## Timing
- Latency: sample accepted on edge N → `glycemicIndex`, alerts and `index_valid` = 1 visible after edge N (one cycle), in both configurations.
- Throughput: one sample per cycle. Back-to-back `sample_valid` gives back-to-back `index_valid` pulses.
- Reset (asynchronous assert, synchronous-safe release):
  - `glycemicIndex` = 4'd0
  - `index_valid` = 0
  - `hypo_alert` = 0
  - `hyper_alert` = 0
  - history h0..h3 = 0
  - primed flag = 0
- Reset mid-stream discards the history. The next sample re-primes the filter.
- `sample_valid` in the first cycle after `rst_n` rises is accepted normally.

## Configuration
- Macro `GLYCEMIC_AVG_FILTER_EN`:
  - Defined: 4-sample moving-average filter with priming, as above.
  - Undefined: R is the raw accepted sample; history registers and the primed flag are not built.
- Ports and latency are identical in both builds.

## Test plan
- No filter: samples 0x11, 0x91, 0x17 on consecutive valid cycles → `glycemicIndex` 1, 9, 1.
  - `hypo_alert` 1, 0, 1.
  - `hyper_alert` 0, 0, 0.
  - `index_valid` high each following cycle.
- Thresholds, no filter: samples 70, 69, 180, 181, 255:
  - `hypo_alert` 0, 1, 0, 0, 0
  - `hyper_alert` 0, 0, 0, 1, 1
  - index for 255 = 15
- Filter enabled: after reset, samples 0x11, 0x91, 0x91, 0x91, 0x91:
  - R = 17, 49, 81, 113, 145
  - index = 1, 3, 5, 7, 9
- Idle hold: a valid sample 0x91, then 5 cycles with `sample_valid` = 0 and `bloodSensor` toggling → index stays 9, `index_valid` low, alerts unchanged.
- Reset mid-operation: with the filter primed at R = 145, assert `rst_n` low asynchronously:
  - Outputs zero immediately.
  - Release, then sample 0x17 → index 1, `hypo_alert` 1 (re-primed, no stale history).

Source files
------------

// File: rtl/glycemic_index_calculator.sv
// Glucose reading -> 4-bit glycemic index code plus hypo/hyper alerts; optional 4-sample mean (GLYCEMIC_AVG_FILTER_EN).
// Latency: one cycle from an accepted sample to glycemicIndex/alerts/index_valid; one sample per cycle.
// Backpressure: none; every sample_valid cycle is accepted, outputs hold while sample_valid is low.
module glycemic_index_calculator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [7:0] bloodSensor,
    output logic [3:0] glycemicIndex,
    output logic       index_valid,
    output logic       hypo_alert,
    output logic       hyper_alert
);

    localparam logic [7:0] HYPO_LIMIT  = 8'd70;
    localparam logic [7:0] HYPER_LIMIT = 8'd180;

    // Effective reading R that drives the index and the alerts.
    logic [7:0] w_reading;

`ifdef GLYCEMIC_AVG_FILTER_EN
    // Averaging window h0..h3: h0 is the incoming sample itself, h1..h3 are the
    // three previously accepted samples. Keeping h0 on the input side lets the
    // mean include the current sample without adding a pipeline stage.
    logic [7:0] r_h1;
    logic [7:0] r_h2;
    logic [7:0] r_h3;
    logic       r_primed;
    logic [7:0] w_h0;
    logic [7:0] w_h1;
    logic [7:0] w_h2;
    logic [7:0] w_h3;
    logic [9:0] w_sum;

    // Build the window; before priming every slot sees the incoming sample,
    // so the first output equals that sample rather than a quarter of it.
    always_comb begin
        w_h0      = bloodSensor;
        w_h1      = r_primed ? r_h1 : bloodSensor;
        w_h2      = r_primed ? r_h2 : bloodSensor;
        w_h3      = r_primed ? r_h3 : bloodSensor;
        w_sum     = {2'b00, w_h0} + {2'b00, w_h1} + {2'b00, w_h2} + {2'b00, w_h3};
        w_reading = w_sum[9:2];
    end

    // Shift the history on each accepted sample; priming fills it with the first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1     <= 8'd0;
            r_h2     <= 8'd0;
            r_h3     <= 8'd0;
            r_primed <= 1'b0;
        end else if (sample_valid) begin
            r_h1     <= w_h0;
            r_h2     <= w_h1;
            r_h3     <= w_h2;
            r_primed <= 1'b1;
        end
    end
`else
    assign w_reading = bloodSensor;
`endif

    // Register index and alerts on accepted samples; index_valid pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glycemicIndex <= 4'd0;
            index_valid   <= 1'b0;
            hypo_alert    <= 1'b0;
            hyper_alert   <= 1'b0;
        end else begin
            index_valid <= sample_valid;
            if (sample_valid) begin
                glycemicIndex <= w_reading[7:4];
                hypo_alert    <= (w_reading < HYPO_LIMIT);
                hyper_alert   <= (w_reading > HYPER_LIMIT);
            end
        end
    end

endmodule

// File: tb/tb_glycemic_index_calculator.sv
module tb_glycemic_index_calculator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] bloodSensor;
    logic [3:0] glycemicIndex;
    logic       index_valid;
    logic       hypo_alert;
    logic       hyper_alert;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    glycemic_index_calculator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .bloodSensor  (bloodSensor),
        .glycemicIndex(glycemicIndex),
        .index_valid  (index_valid),
        .hypo_alert   (hypo_alert),
        .hyper_alert  (hyper_alert)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps every sample accepted since reset; the effective reading is the raw
    // newest sample, or (filter build) the mean of the newest four, where slots
    // older than the first accepted sample count as that first sample.
    int         acc[$];
    logic [3:0] m_idx   = 4'd0;
    logic       m_vld   = 1'b0;
    logic       m_hypo  = 1'b0;
    logic       m_hyper = 1'b0;

    function automatic int eff_reading();
`ifdef GLYCEMIC_AVG_FILTER_EN
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = acc.size() - 1 - k;
            s += (j >= 0) ? acc[j] : acc[0];
        end
        return s / 4;
`else
        return acc[acc.size() - 1];
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc.delete();
            m_idx   <= 4'd0;
            m_vld   <= 1'b0;
            m_hypo  <= 1'b0;
            m_hyper <= 1'b0;
        end else if (sample_valid) begin
            int r;
            acc.push_back(int'(bloodSensor));
            r = eff_reading();
            m_idx   <= 4'(r / 16);
            m_vld   <= 1'b1;
            m_hypo  <= (r < 70);
            m_hyper <= (r > 180);
        end else begin
            m_vld <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_index", int'(glycemicIndex), int'(m_idx));
            chk("cmp_valid", int'(index_valid), int'(m_vld));
            chk("cmp_hypo", int'(hypo_alert), int'(m_hypo));
            chk("cmp_hyper", int'(hyper_alert), int'(m_hyper));
            checks++;
            if (hypo_alert === 1'b1 && hyper_alert === 1'b1) begin
                failures++;
                $display("FAIL cmp_exclusive actual=both_alerts required=at_most_one");
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    // Called at a falling edge: present a sample, then check it one edge later.
    task automatic send(input logic [7:0] s, input int ei, input int eh, input int er, input string nm);
        sample_valid = 1'b1;
        bloodSensor  = s;
        @(negedge clk);
        chk({nm, "_index"}, int'(glycemicIndex), ei);
        chk({nm, "_hypo"}, int'(hypo_alert), eh);
        chk({nm, "_hyper"}, int'(hyper_alert), er);
        chk({nm, "_valid"}, int'(index_valid), 1);
    endtask

    task automatic idle_hold(input int n, input int ei, input int eh, input int er);
        sample_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bloodSensor = (i % 2 == 0) ? 8'h00 : 8'hFF;
            @(negedge clk);
            chk("idle_index", int'(glycemicIndex), ei);
            chk("idle_hypo", int'(hypo_alert), eh);
            chk("idle_hyper", int'(hyper_alert), er);
            chk("idle_valid", int'(index_valid), 0);
        end
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_index", int'(glycemicIndex), 0);
        chk("rst_valid", int'(index_valid), 0);
        chk("rst_hypo", int'(hypo_alert), 0);
        chk("rst_hyper", int'(hyper_alert), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        bloodSensor  = 8'h00;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        do_reset();

        // Basic conversion, back-to-back samples.
`ifdef GLYCEMIC_AVG_FILTER_EN
        send(8'h11, 1, 1, 0, "basic0");
        send(8'h91, 3, 1, 0, "basic1");
        send(8'h17, 3, 1, 0, "basic2");
`else
        send(8'h11, 1, 1, 0, "basic0");
        send(8'h91, 9, 0, 0, "basic1");
        send(8'h17, 1, 1, 0, "basic2");
`endif
        idle_hold(1, int'(glycemicIndex), int'(hypo_alert), int'(hyper_alert));

        // Threshold boundaries.
        do_reset();
`ifdef GLYCEMIC_AVG_FILTER_EN
        send(8'd70,  4, 0, 0, "thr70");
        send(8'd69,  4, 1, 0, "thr69");
        send(8'd180, 6, 0, 0, "thr180");
        send(8'd181, 7, 0, 0, "thr181");
        send(8'd255, 10, 0, 0, "thr255");
`else
        send(8'd70,  4, 0, 0, "thr70");
        send(8'd69,  4, 1, 0, "thr69");
        send(8'd180, 11, 0, 0, "thr180");
        send(8'd181, 11, 0, 1, "thr181");
        send(8'd255, 15, 0, 1, "thr255");
`endif

        // Priming and averaging sequence, then idle hold at index 9.
        do_reset();
`ifdef GLYCEMIC_AVG_FILTER_EN
        send(8'h11, 1, 1, 0, "avg0");
        send(8'h91, 3, 1, 0, "avg1");
        send(8'h91, 5, 0, 0, "avg2");
        send(8'h91, 7, 0, 0, "avg3");
        send(8'h91, 9, 0, 0, "avg4");
`else
        send(8'h11, 1, 1, 0, "avg0");
        send(8'h91, 9, 0, 0, "avg1");
        send(8'h91, 9, 0, 0, "avg2");
        send(8'h91, 9, 0, 0, "avg3");
        send(8'h91, 9, 0, 0, "avg4");
`endif
        idle_hold(5, 9, 0, 0);

        // Asynchronous reset mid-stream, then re-prime from a fresh sample.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_index", int'(glycemicIndex), 0);
        chk("async_valid", int'(index_valid), 0);
        chk("async_hypo", int'(hypo_alert), 0);
        chk("async_hyper", int'(hyper_alert), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h17, 1, 1, 0, "rearm");
        idle_hold(2, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
